// File: rtl/microwave_bcd_timer.sv
// rtl/microwave_bcd_timer.sv - three-digit BCD microwave countdown timer with keypad shift-in entry
// Optional QUICK_ADD_EN adds an add30 strobe that adds 30 s (saturating at 9:59).
module microwave_bcd_timer #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digit_valid,
  input  logic [3:0] digit,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       door_closed,
`ifdef QUICK_ADD_EN
  input  logic       add30,
`endif
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       running,
  output logic       done
);

  localparam int PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [11:0]   cur_t;
  logic [11:0]   run_t;
  logic          tick;

  assign cur_t = {mins, sec_tens, sec_ones};
  assign tick  = (presc == PW'(TICK_DIV - 1));

  // Borrow chain: seconds wrap 0->9, tens wrap 0->5, so entered tens above 5 just count down.
  function automatic logic [11:0] bcd_dec(input logic [11:0] t);
    logic [3:0] m, s10, s1;
    {m, s10, s1} = t;
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        m   = m - 4'd1;
      end
    end
    return {m, s10, s1};
  endfunction

`ifdef QUICK_ADD_EN
  logic [11:0] add_t;

  // Unnormalised tens (e.g. 0:75) fold into minutes first so the +3 carry stays single-step.
  function automatic logic [11:0] bcd_add30(input logic [11:0] t);
    logic [4:0] m;
    logic [3:0] s10;
    m   = {1'b0, t[11:8]};
    s10 = t[7:4];
    if (s10 > 4'd5) begin
      s10 = s10 - 4'd6;
      m   = m + 5'd1;
    end
    s10 = s10 + 4'd3;
    if (s10 > 4'd5) begin
      s10 = s10 - 4'd6;
      m   = m + 5'd1;
    end
    if (m > 5'd9) return 12'h959;
    return {m[3:0], s10, t[3:0]};
  endfunction

  assign add_t = bcd_add30(cur_t);
`endif

  // Time loaded while counting; an add30 coinciding with a tick is applied before the decrement.
  always_comb begin
    run_t = tick ? bcd_dec(cur_t) : cur_t;
`ifdef QUICK_ADD_EN
    if (add30) run_t = tick ? bcd_dec(add_t) : add_t;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                        <= IDLE;
      {mins, sec_tens, sec_ones}   <= 12'h000;
      presc                        <= '0;
      running                      <= 1'b0;
      done                         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state                      <= IDLE;
        {mins, sec_tens, sec_ones} <= 12'h000;
        presc                      <= '0;
        running                    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && door_closed && (cur_t != 12'h000)) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
`ifdef QUICK_ADD_EN
            else if (add30) begin
              {mins, sec_tens, sec_ones} <= add_t;
              if (door_closed) begin
                state   <= RUN;
                presc   <= '0;
                running <= 1'b1;
              end
            end
`endif
            else if (digit_valid && (digit <= 4'd9)) begin
              {mins, sec_tens, sec_ones} <= {sec_tens, sec_ones, digit};
            end
          end
          RUN: begin
            if (!door_closed || stop) begin
              state   <= PAUSE;
              running <= 1'b0;
            end else begin
              presc                      <= tick ? '0 : presc + PW'(1);
              {mins, sec_tens, sec_ones} <= run_t;
              if (tick && (run_t == 12'h000)) begin
                state   <= IDLE;
                running <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (start && door_closed) begin
              state   <= RUN;
              presc   <= '0;
              running <= 1'b1;
            end
`ifdef QUICK_ADD_EN
            else if (add30) begin
              {mins, sec_tens, sec_ones} <= add_t;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microwave_bcd_timer.sv
// tb/tb_microwave_bcd_timer.sv - directed self-checking bench for microwave_bcd_timer (TICK_DIV=4)
module tb_microwave_bcd_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clear = 1'b0;
  logic       door_closed = 1'b1;
`ifdef QUICK_ADD_EN
  logic       add30 = 1'b0;
`endif
  logic [3:0] sec_ones, sec_tens, mins;
  logic       running, done;
  logic [11:0] disp;

  int errors = 0;
  int checks = 0;

  assign disp = {mins, sec_tens, sec_ones};

  microwave_bcd_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .digit_valid(digit_valid), .digit(digit),
    .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
`ifdef QUICK_ADD_EN
    .add30(add30),
`endif
    .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
    .running(running), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input logic [3:0] d);
    digit = d; digit_valid = 1'b1;
    @(negedge clk);
    digit_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    cyc(2);
    checks++; if (disp !== 12'h000) begin errors++; $display("FAIL reset_time: got %h want 000", disp); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic test_countdown();
    key(4'd1); key(4'd3); key(4'd0);
    checks++; if (disp !== 12'h130) begin errors++; $display("FAIL entry_130: got %h want 130", disp); end
    key(4'hA);
    checks++; if (disp !== 12'h130) begin errors++; $display("FAIL entry_bad_digit: got %h want 130", disp); end
    press_start();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %b want 1", running); end
    cyc(3);
    checks++; if (disp !== 12'h130) begin errors++; $display("FAIL pre_tick: got %h want 130", disp); end
    cyc(1);
    checks++; if (disp !== 12'h129) begin errors++; $display("FAIL first_tick: got %h want 129", disp); end
    cyc(29 * 4);
    checks++; if (disp !== 12'h100) begin errors++; $display("FAIL at_100: got %h want 100", disp); end
    cyc(4);
    checks++; if (disp !== 12'h059) begin errors++; $display("FAIL min_borrow: got %h want 059", disp); end
    press_clear();
    checks++; if (disp !== 12'h000 || running !== 1'b0) begin errors++; $display("FAIL clear_run: got %h run=%b want 000 run=0", disp, running); end
  endtask

  task automatic test_expiry();
    key(4'd5);
    press_start();
    cyc(16);
    checks++; if (disp !== 12'h001 || done !== 1'b0) begin errors++; $display("FAIL exp_001: got %h done=%b want 001 done=0", disp, done); end
    cyc(3);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL exp_early_done: got %b want 0", done); end
    cyc(1);
    checks++; if (disp !== 12'h000) begin errors++; $display("FAIL exp_zero: got %h want 000", disp); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL exp_done: got %b want 1", done); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL exp_running: got %b want 0", running); end
    cyc(1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL exp_done_width: got %b want 0", done); end
    key(4'd7);
    checks++; if (disp !== 12'h007) begin errors++; $display("FAIL exp_idle_entry: got %h want 007", disp); end
    press_clear();
  endtask

  task automatic test_door_pause();
    key(4'd4); key(4'd5);
    press_start();
    cyc(2);
    door_closed = 1'b0;
    cyc(1);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL door_running: got %b want 0", running); end
    cyc(10);
    checks++; if (disp !== 12'h045) begin errors++; $display("FAIL door_frozen: got %h want 045", disp); end
    press_start();
    checks++; if (running !== 1'b0 || disp !== 12'h045) begin errors++; $display("FAIL door_open_start: got %h run=%b want 045 run=0", disp, running); end
    door_closed = 1'b1;
    cyc(2);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL door_close_no_resume: got %b want 0", running); end
    press_start();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running: got %b want 1", running); end
    cyc(3);
    checks++; if (disp !== 12'h045) begin errors++; $display("FAIL resume_pre_tick: got %h want 045", disp); end
    cyc(1);
    checks++; if (disp !== 12'h044) begin errors++; $display("FAIL resume_tick: got %h want 044", disp); end
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(8);
    checks++; if (disp !== 12'h044 || running !== 1'b0) begin errors++; $display("FAIL stop_hold: got %h run=%b want 044 run=0", disp, running); end
    press_clear();
  endtask

  task automatic test_bcd_tens();
    key(4'd9); key(4'd9);
    checks++; if (disp !== 12'h099) begin errors++; $display("FAIL entry_099: got %h want 099", disp); end
    key(4'hA);
    checks++; if (disp !== 12'h099) begin errors++; $display("FAIL entry_099_bad: got %h want 099", disp); end
    press_start();
    cyc(4);
    checks++; if (disp !== 12'h098) begin errors++; $display("FAIL tens_098: got %h want 098", disp); end
    key(4'd3);
    cyc(31);
    checks++; if (disp !== 12'h090) begin errors++; $display("FAIL tens_090: got %h want 090", disp); end
    cyc(4);
    checks++; if (disp !== 12'h089) begin errors++; $display("FAIL tens_089: got %h want 089", disp); end
    press_clear();
  endtask

  task automatic test_clear_priority();
    key(4'd2); key(4'd1); key(4'd0);
    press_start();
    cyc(2);
    clear = 1'b1; start = 1'b1;
    cyc(1);
    clear = 1'b0; start = 1'b0;
    checks++; if (disp !== 12'h000 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL clear_start: got %h run=%b done=%b want 000 0 0", disp, running, done); end
    cyc(8);
    checks++; if (running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL clear_stays_idle: run=%b done=%b want 0 0", running, done); end
  endtask

  task automatic test_async_reset();
    key(4'd2); key(4'd1); key(4'd0);
    press_start();
    cyc(5);
    checks++; if (disp !== 12'h209) begin errors++; $display("FAIL pre_reset: got %h want 209", disp); end
    #2 reset = 1'b1;
    #1;
    checks++; if (disp !== 12'h000 || running !== 1'b0) begin errors++; $display("FAIL async_reset: got %h run=%b want 000 run=0", disp, running); end
    @(negedge clk);
    reset = 1'b0;
    cyc(1);
  endtask

`ifdef QUICK_ADD_EN
  task automatic pulse_add30();
    add30 = 1'b1;
    @(negedge clk);
    add30 = 1'b0;
  endtask

  task automatic test_quick_add();
    door_closed = 1'b1;
    pulse_add30();
    checks++; if (disp !== 12'h030 || running !== 1'b1) begin errors++; $display("FAIL add_idle: got %h run=%b want 030 run=1", disp, running); end
    press_clear();
    key(4'd4); key(4'd5);
    pulse_add30();
    checks++; if (disp !== 12'h115) begin errors++; $display("FAIL add_045: got %h want 115", disp); end
    press_clear();
    key(4'd9); key(4'd4); key(4'd5);
    pulse_add30();
    checks++; if (disp !== 12'h959) begin errors++; $display("FAIL add_sat: got %h want 959", disp); end
    press_clear();
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_expiry();
    test_door_pause();
    test_bcd_tens();
    test_clear_priority();
    test_async_reset();
`ifdef QUICK_ADD_EN
    test_quick_add();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
